dsram_confreg_resp: RTL and testbench

//  Responder for the CPU data_sram port (en/wen/addr/wdata/rdata).

---
 rtl/dsram_pkg.sv | 16 +
 rtl/dsram_confreg_resp_if.sv | 12 +
 rtl/dsram_confreg_resp_bram_be_sp.sv | 22 ++
 rtl/dsram_confreg_resp.sv | 82 ++++++++
 tb/tb_dsram_confreg_resp.sv | 130 +++++++++++++
 5 files changed

// File: rtl/dsram_pkg.sv
// dsram_pkg: shared constants and helpers for the data_sram responder
package dsram_pkg;
    localparam int DW = 32;
    localparam logic [15:0] CR_BASE  = 16'h1faf;
    localparam logic [15:0] CR_SCR0  = 16'h8000;
    localparam logic [15:0] CR_TIMER = 16'he000;
    localparam logic [15:0] CR_LED   = 16'hf000;
    localparam logic [15:0] CR_NUM   = 16'hf010;
    localparam logic [15:0] CR_SW    = 16'hf020;

    function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v, input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) old_v[8*i +: 8] = new_v[8*i +: 8];
        return old_v;
    endfunction
endpackage

// File: rtl/dsram_confreg_resp_if.sv
// dsram_confreg_resp_if: CPU data_sram request/response bundle
interface dsram_confreg_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output en, wen, addr, wdata, input rdata, rvalid);
    modport slave (input en, wen, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/dsram_confreg_resp_bram_be_sp.sv
// bram_be_sp: single-port RAM, synchronous read, per-byte write enables
module bram_be_sp #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];

    // write enabled bytes and capture the pre-write word on every access
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dsram_confreg_resp.sv
// dsram_confreg_resp: data RAM plus memory-mapped config registers behind the data_sram port
module dsram_confreg_resp import dsram_pkg::*; #(
    parameter int RAM_AW = 14,
    parameter int SW_W = 8,
    parameter logic [15:0] CR_BASE = dsram_pkg::CR_BASE
) (
    input  logic            clk,
    input  logic            rst,
    dsram_confreg_resp_if.slave bus,
    output logic [15:0]     led,
    output logic [31:0]     num,
    input  logic [SW_W-1:0] sw
);
    logic          cr_sel, cr_we, rd_req, scr_hit;
    logic [13:0]   off;
    logic [DW-1:0] cr [8];
    logic [DW-1:0] timer, cr_rd, cr_q, ram_q, last_q;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic          req_q, sel_q;
    logic          unused_lo;

    assign cr_sel    = bus.addr[31:16] == CR_BASE;
    assign off       = bus.addr[15:2];
    assign unused_lo = ^bus.addr[1:0];
    assign rd_req    = bus.en && bus.wen == 4'b0;
    assign cr_we     = bus.en && |bus.wen && cr_sel && !rst;
    assign scr_hit   = off[13:3] == CR_SCR0[15:5];

    bram_be_sp #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (bus.en && !cr_sel && !rst),
        .we    (bus.wen),
        .addr  (bus.addr[RAM_AW+1:2]),
        .wdata (bus.wdata),
        .rdata (ram_q)
    );

    // config-register read mux; unmapped offsets read as zero
    always_comb begin
        cr_rd = scr_hit                 ? cr[off[2:0]] :
                off == CR_TIMER[15:2]   ? timer :
                off == CR_LED[15:2]     ? {16'b0, led} :
                off == CR_NUM[15:2]     ? num :
                off == CR_SW[15:2]      ? DW'(sw_s2) : '0;
    end

    // config registers, timer, switch synchroniser and read pipeline stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cr[i] <= '0;
            timer  <= '0;
            led    <= '0;
            num    <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            req_q  <= 1'b0;
            sel_q  <= 1'b0;
            cr_q   <= '0;
            last_q <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            req_q  <= rd_req;
            last_q <= bus.rdata;
            if (rd_req) begin
                sel_q <= cr_sel;
                cr_q  <= cr_rd;
            end
            if (cr_we && scr_hit) cr[off[2:0]] <= be_merge(cr[off[2:0]], bus.wdata, bus.wen);
            timer <= (cr_we && off == CR_TIMER[15:2]) ? be_merge(timer, bus.wdata, bus.wen) : timer + 1'b1;
            if (cr_we && off == CR_LED[15:2]) led <= 16'(be_merge({16'b0, led}, bus.wdata, {2'b0, bus.wen[1:0]}));
            if (cr_we && off == CR_NUM[15:2]) num <= be_merge(num, bus.wdata, bus.wen);
        end
    end

    // rdata changes only on a completed read, otherwise holds the last value
    always_comb begin
        bus.rdata = req_q ? (sel_q ? cr_q : ram_q) : last_q;
    end

    assign bus.rvalid = req_q;
endmodule

// File: tb/tb_dsram_confreg_resp.sv
// tb_dsram_confreg_resp: directed self-checking bench for dsram_confreg_resp
module tb_dsram_confreg_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led;
    logic [31:0] num;
    logic [7:0]  sw = 8'h00;
    int pass = 0;
    int total = 0;

    dsram_confreg_resp_if bus();

    dsram_confreg_resp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led),
        .num (num),
        .sw  (sw)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.en = e;
        bus.wen = w;
        bus.addr = a;
        bus.wdata = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.rdata); else pass++;
        total++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); else pass++;
        total++; if (led !== 16'h0) $display("FAIL reset_led got=%h exp=0", led); else pass++;
        total++; if (num !== 32'h0) $display("FAIL reset_num got=%h exp=0", num); else pass++;
        rst = 1'b0;
        drive(1'b1, 4'h0, 32'h1fafe000, 32'h0);
        total++; if (bus.rvalid !== 1'b1) $display("FAIL reset_timer_rvalid got=%b exp=1", bus.rvalid); else pass++;
        total++; if (bus.rdata > 32'd2) $display("FAIL reset_timer got=%h exp=0..2", bus.rdata); else pass++;
    endtask

    task automatic test_ram_bytes();
        drive(1'b1, 4'hf, 32'h00000010, 32'haabbccdd);
        drive(1'b1, 4'b0100, 32'h00000010, 32'h11223344);
        total++; if (bus.rvalid !== 1'b0) $display("FAIL ram_wr_rvalid got=%b exp=0", bus.rvalid); else pass++;
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        total++; if (bus.rvalid !== 1'b1) $display("FAIL ram_rd_rvalid got=%b exp=1", bus.rvalid); else pass++;
        total++; if (bus.rdata !== 32'haa22ccdd) $display("FAIL ram_rd got=%h exp=aa22ccdd", bus.rdata); else pass++;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        total++; if (bus.rvalid !== 1'b0) $display("FAIL ram_idle_rvalid got=%b exp=0", bus.rvalid); else pass++;
        total++; if (bus.rdata !== 32'haa22ccdd) $display("FAIL ram_hold got=%h exp=aa22ccdd", bus.rdata); else pass++;
        drive(1'b1, 4'h0, 32'h00010010, 32'h0);
        total++; if (bus.rdata !== 32'haa22ccdd) $display("FAIL ram_alias got=%h exp=aa22ccdd", bus.rdata); else pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'hf, 32'h1faf800c, 32'h12345678);
        drive(1'b1, 4'h0, 32'h1faf800c, 32'h0);
        total++; if (bus.rdata !== 32'h12345678) $display("FAIL b2b_cr3 got=%h exp=12345678", bus.rdata); else pass++;
        drive(1'b1, 4'h0, 32'h1faf8008, 32'h0);
        total++; if (bus.rdata !== 32'h0) $display("FAIL b2b_cr2 got=%h exp=0", bus.rdata); else pass++;
        drive(1'b1, 4'h0, 32'h1faf8100, 32'h0);
        total++; if (bus.rdata !== 32'h0) $display("FAIL unmapped got=%h exp=0", bus.rdata); else pass++;
        drive(1'b1, 4'hf, 32'h00000020, 32'hdeadbeef);
        drive(1'b1, 4'h0, 32'h00000020, 32'h0);
        total++; if (bus.rdata !== 32'hdeadbeef) $display("FAIL b2b_ram got=%h exp=deadbeef", bus.rdata); else pass++;
    endtask

    task automatic test_timer();
        drive(1'b1, 4'hf, 32'h1fafe000, 32'hfffffffe);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 32'h1fafe000, 32'h0);
        total++; if (bus.rdata !== 32'h0) $display("FAIL timer_wrap got=%h exp=0", bus.rdata); else pass++;
        drive(1'b1, 4'b0001, 32'h1fafe000, 32'h000000f0);
        drive(1'b1, 4'h0, 32'h1fafe000, 32'h0);
        total++; if (bus.rdata !== 32'h000000f0) $display("FAIL timer_byte got=%h exp=000000f0", bus.rdata); else pass++;
    endtask

    task automatic test_led_sw();
        drive(1'b1, 4'hf, 32'h1faff000, 32'hffff5a5a);
        total++; if (led !== 16'h5a5a) $display("FAIL led got=%h exp=5a5a", led); else pass++;
        drive(1'b1, 4'hf, 32'h1faff010, 32'hcafef00d);
        total++; if (num !== 32'hcafef00d) $display("FAIL num got=%h exp=cafef00d", num); else pass++;
        drive(1'b1, 4'h0, 32'h1faff000, 32'h0);
        total++; if (bus.rdata !== 32'h00005a5a) $display("FAIL led_rd got=%h exp=00005a5a", bus.rdata); else pass++;
        sw = 8'ha5;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 32'h1faff020, 32'h0);
        total++; if (bus.rdata !== 32'h000000a5) $display("FAIL sw_rd got=%h exp=000000a5", bus.rdata); else pass++;
        drive(1'b1, 4'hf, 32'h1faff020, 32'hffffffff);
        drive(1'b1, 4'h0, 32'h1faff020, 32'h0);
        total++; if (bus.rdata !== 32'h000000a5) $display("FAIL sw_ro got=%h exp=000000a5", bus.rdata); else pass++;
    endtask

    task automatic test_reset_read();
        rst = 1'b1;
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        total++; if (bus.rvalid !== 1'b0) $display("FAIL rst_rd_rvalid got=%b exp=0", bus.rvalid); else pass++;
        total++; if (bus.rdata !== 32'h0) $display("FAIL rst_rd_rdata got=%h exp=0", bus.rdata); else pass++;
        total++; if (led !== 16'h0) $display("FAIL rst_led got=%h exp=0", led); else pass++;
        rst = 1'b0;
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        total++; if (bus.rdata !== 32'haa22ccdd) $display("FAIL rst_ram_kept got=%h exp=aa22ccdd", bus.rdata); else pass++;
        drive(1'b1, 4'h0, 32'h1faf800c, 32'h0);
        total++; if (bus.rdata !== 32'h0) $display("FAIL rst_cr3 got=%h exp=0", bus.rdata); else pass++;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.wen = 4'h0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_ram_bytes();
        test_back_to_back();
        test_timer();
        test_led_sw();
        test_reset_read();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
